// File: rtl/tx_symbol_serializer_if.sv
// Stream bundle for the transmit symbol serializer.
// The upstream word handshake and the downstream symbol stream are grouped
// here so that the producer (master) and the serializer (slave) see
// complementary directions.
interface tx_symbol_serializer_if #(
  parameter int DATAW = 8,
  parameter int SYMW  = 2
);

  // Word side: upstream -> serializer
  logic [DATAW-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;

  // Symbol side: serializer -> PHY-facing logic
  logic [SYMW-1:0]  sym_data;
  logic             sym_valid;
  logic             sym_last;

  // Status
  logic             busy;

  // Producer of words and consumer of symbols
  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  sym_data,
    input  sym_valid,
    input  sym_last,
    input  busy
  );

  // The serializer itself
  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output sym_data,
    output sym_valid,
    output sym_last,
    output busy
  );

endinterface

// File: rtl/tx_symbol_serializer.sv
// Parallel-in, serial-out symbol serializer for the Ethernet transmit path.
// DATAW-bit words arrive over a valid/ready handshake and leave LSB-first as
// SYMW-bit symbols, one symbol per enable strobe. A one-word holding buffer
// in front of the shifter lets consecutive words stream without a gap.
// SYMW must divide DATAW (and therefore SYMW <= DATAW).
module tx_symbol_serializer #(
  parameter int DATAW = 8,
  parameter int SYMW  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  tx_symbol_serializer_if.slave        bus
);

  // Symbols per word and width of the "symbols remaining" counter.
  localparam int RATIO = DATAW / SYMW;
  localparam int CNTW  = $clog2(RATIO + 1);

  localparam logic [CNTW-1:0]  CNT_ZERO  = {CNTW{1'b0}};
  localparam logic [CNTW-1:0]  CNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0]  CNT_FULL  = CNTW'(RATIO);
  localparam logic [CNTW-1:0]  CNT_FIRST = CNTW'(RATIO - 1);
  localparam logic             RATIO_IS_ONE = (RATIO == 1);

  localparam logic [DATAW-1:0] DATA_ZERO = {DATAW{1'b0}};
  localparam logic [SYMW-1:0]  SYM_ZERO  = {SYMW{1'b0}};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  // Holding buffer: the word waiting behind the shifter.
  logic [DATAW-1:0] hold_data_r;
  logic             hold_last_r;
  logic             hold_valid_r;

  // Shifter: the word currently being emitted, already shifted so that the
  // next symbol to go out sits in the low SYMW bits.
  logic [DATAW-1:0] sh_data_r;
  logic             sh_last_r;
  logic [CNTW-1:0]  cnt_r;

  // Registered symbol outputs.
  logic [SYMW-1:0]  sym_data_r;
  logic             sym_valid_r;
  logic             sym_last_r;

  // ---------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------
  logic [DATAW-1:0] hold_data_nx_s;
  logic             hold_last_nx_s;
  logic             hold_valid_nx_s;

  logic [DATAW-1:0] sh_data_nx_s;
  logic             sh_last_nx_s;
  logic [CNTW-1:0]  cnt_nx_s;

  logic [SYMW-1:0]  sym_data_nx_s;
  logic             sym_valid_nx_s;
  logic             sym_last_nx_s;

  // Handshake helpers
  logic             hold_drain_s;
  logic             in_ready_s;
  logic             accept_s;

  // The holding word leaves the buffer on an enable edge where the shifter
  // is on its last symbol (reload) or already empty (direct start). This is
  // what lets a new word be accepted on the same edge the old one drains,
  // which in turn keeps RATIO==1 running at one word per enable.
  always_comb begin
    hold_drain_s = enable && (cnt_r <= CNT_ONE) && hold_valid_r;
  end

  // Ready depends only on enable and registered state, never on in_valid,
  // so upstream may legally wait for ready before raising valid.
  always_comb begin
    in_ready_s = !reset && (!hold_valid_r || hold_drain_s);
    accept_s   = bus.in_valid && in_ready_s;
  end

  // Holding buffer next state: load on accept (which also covers a reload
  // on the edge the buffer drains), otherwise empty it when it drains.
  always_comb begin
    hold_data_nx_s  = hold_data_r;
    hold_last_nx_s  = hold_last_r;
    hold_valid_nx_s = hold_valid_r;
    if (accept_s) begin
      hold_data_nx_s  = bus.in_data;
      hold_last_nx_s  = bus.in_last;
      hold_valid_nx_s = 1'b1;
    end else if (hold_drain_s) begin
      hold_valid_nx_s = 1'b0;
    end else begin
      hold_valid_nx_s = hold_valid_r;
    end
  end

  // Shifter and symbol output next state. Everything here advances only on
  // enable; between strobes the current symbol is held on the outputs.
  always_comb begin
    sh_data_nx_s   = sh_data_r;
    sh_last_nx_s   = sh_last_r;
    cnt_nx_s       = cnt_r;
    sym_data_nx_s  = sym_data_r;
    sym_valid_nx_s = sym_valid_r;
    sym_last_nx_s  = sym_last_r;
    if (enable) begin
      case (cnt_r)
        CNT_ZERO: begin
          if (hold_valid_r) begin
            // Shifter empty: start the held word straight away, sending its
            // first symbol now and parking the rest in the shifter.
            sym_data_nx_s  = hold_data_r[SYMW-1:0];
            sym_valid_nx_s = 1'b1;
            sym_last_nx_s  = hold_last_r && RATIO_IS_ONE;
            sh_data_nx_s   = hold_data_r >> SYMW;
            sh_last_nx_s   = hold_last_r;
            cnt_nx_s       = CNT_FIRST;
          end else begin
            // Idle or underrun: drive a clean zero symbol with TX_EN low.
            sym_data_nx_s  = SYM_ZERO;
            sym_valid_nx_s = 1'b0;
            sym_last_nx_s  = 1'b0;
          end
        end
        CNT_ONE: begin
          // Final symbol of the current word; it carries the frame-end tag.
          sym_data_nx_s  = sh_data_r[SYMW-1:0];
          sym_valid_nx_s = 1'b1;
          sym_last_nx_s  = sh_last_r;
          if (hold_valid_r) begin
            // Reload from the buffer so the next word follows gaplessly.
            sh_data_nx_s = hold_data_r;
            sh_last_nx_s = hold_last_r;
            cnt_nx_s     = CNT_FULL;
          end else begin
            cnt_nx_s     = CNT_ZERO;
          end
        end
        default: begin
          // Mid-word: emit and shift the next symbol down into place.
          sym_data_nx_s  = sh_data_r[SYMW-1:0];
          sym_valid_nx_s = 1'b1;
          sym_last_nx_s  = 1'b0;
          sh_data_nx_s   = sh_data_r >> SYMW;
          cnt_nx_s       = cnt_r - CNT_ONE;
        end
      endcase
    end else begin
      sh_data_nx_s   = sh_data_r;
      sh_last_nx_s   = sh_last_r;
      cnt_nx_s       = cnt_r;
      sym_data_nx_s  = sym_data_r;
      sym_valid_nx_s = sym_valid_r;
      sym_last_nx_s  = sym_last_r;
    end
  end

  // State register with synchronous reset; a reset mid-word discards both
  // the buffer and the shifter so no partial symbol survives it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_data_r  <= DATA_ZERO;
      hold_last_r  <= 1'b0;
      hold_valid_r <= 1'b0;
      sh_data_r    <= DATA_ZERO;
      sh_last_r    <= 1'b0;
      cnt_r        <= CNT_ZERO;
      sym_data_r   <= SYM_ZERO;
      sym_valid_r  <= 1'b0;
      sym_last_r   <= 1'b0;
    end else begin
      hold_data_r  <= hold_data_nx_s;
      hold_last_r  <= hold_last_nx_s;
      hold_valid_r <= hold_valid_nx_s;
      sh_data_r    <= sh_data_nx_s;
      sh_last_r    <= sh_last_nx_s;
      cnt_r        <= cnt_nx_s;
      sym_data_r   <= sym_data_nx_s;
      sym_valid_r  <= sym_valid_nx_s;
      sym_last_r   <= sym_last_nx_s;
    end
  end

  // Outputs: symbol stream straight from registers, busy from state only.
  assign bus.in_ready  = in_ready_s;
  assign bus.sym_data  = sym_data_r;
  assign bus.sym_valid = sym_valid_r;
  assign bus.sym_last  = sym_last_r;
  assign bus.busy      = hold_valid_r || (cnt_r != CNT_ZERO);

endmodule

// File: tb/tb_tx_symbol_serializer.sv
// Directed bench for tx_symbol_serializer: one DUT as byte->dibit (SYMW=2)
// and one as byte->byte (SYMW=8). Inputs change and outputs are sampled on
// the falling clock edge, away from the active rising edge.
module tb_tx_symbol_serializer;

  logic clk;
  logic rst;
  logic en;

  int checks;
  int passed;

  tx_symbol_serializer_if #(.DATAW(8), .SYMW(2)) bus2 ();
  tx_symbol_serializer_if #(.DATAW(8), .SYMW(8)) bus8 ();

  tx_symbol_serializer #(.DATAW(8), .SYMW(2)) u_dut2 (
    .clk    (clk),
    .reset  (rst),
    .enable (en),
    .bus    (bus2)
  );

  tx_symbol_serializer #(.DATAW(8), .SYMW(8)) u_dut8 (
    .clk    (clk),
    .reset  (rst),
    .enable (en),
    .bus    (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [5:0] got;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) step();
    got = {bus2.sym_valid, bus2.sym_last, bus2.sym_data, bus2.busy, bus2.in_ready};
    checks++;
    if (got !== 6'b0) $display("FAIL reset_outputs: got v/l/d/busy/rdy=%b want 000000", got);
    else passed++;
    checks++;
    if (bus8.in_ready !== 1'b0) $display("FAIL reset_ready8: got %b want 0", bus8.in_ready);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (bus2.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus2.in_ready);
    else passed++;
  endtask

  task automatic test_single;
    logic [1:0] exp [4];
    logic [3:0] got, want;
    exp[0] = 2'd0; exp[1] = 2'd1; exp[2] = 2'd3; exp[3] = 2'd2;
    step();
    bus2.in_data = 8'hB4; bus2.in_last = 1'b1; bus2.in_valid = 1'b1;
    step();
    bus2.in_valid = 1'b0;
    checks++;
    if ({bus2.sym_valid, bus2.busy} !== 2'b01) $display("FAIL single_latency: got valid/busy=%b want 01", {bus2.sym_valid, bus2.busy});
    else passed++;
    for (int k = 0; k < 4; k++) begin
      step();
      got  = {bus2.sym_valid, bus2.sym_last, bus2.sym_data};
      want = {1'b1, (k == 3), exp[k]};
      checks++;
      if (got !== want) $display("FAIL single_sym%0d: got v/l/d=%b want %b", k, got, want);
      else passed++;
    end
    step();
    got = {bus2.sym_valid, bus2.sym_last, bus2.sym_data};
    checks++;
    if ({got, bus2.busy} !== 5'b0) $display("FAIL single_end: got v/l/d/busy=%b want 00000", {got, bus2.busy});
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp [8];
    logic [3:0] got, want;
    exp[0] = 2'd0; exp[1] = 2'd1; exp[2] = 2'd3; exp[3] = 2'd2;
    exp[4] = 2'd2; exp[5] = 2'd2; exp[6] = 2'd1; exp[7] = 2'd1;
    step();
    bus2.in_data = 8'hB4; bus2.in_last = 1'b0; bus2.in_valid = 1'b1;
    step();
    checks++;
    if (bus2.in_ready !== 1'b1) $display("FAIL b2b_ready_drain: got %b want 1", bus2.in_ready);
    else passed++;
    bus2.in_data = 8'h5A; bus2.in_last = 1'b1;
    step();
    bus2.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      got  = {bus2.sym_valid, bus2.sym_last, bus2.sym_data};
      want = {1'b1, (k == 7), exp[k]};
      checks++;
      if (got !== want) $display("FAIL b2b_sym%0d: got v/l/d=%b want %b", k, got, want);
      else passed++;
      if (k < 2) begin
        checks++;
        if (bus2.in_ready !== 1'b0) $display("FAIL b2b_ready_full%0d: got %b want 0", k, bus2.in_ready);
        else passed++;
      end
    end
    step();
    checks++;
    if (bus2.sym_valid !== 1'b0) $display("FAIL b2b_end: got valid=%b want 0", bus2.sym_valid);
    else passed++;
  endtask

  task automatic test_slow_strobe;
    logic [1:0] exp [4];
    logic [3:0] got, want;
    exp[0] = 2'd0; exp[1] = 2'd1; exp[2] = 2'd3; exp[3] = 2'd2;
    step();
    en = 1'b0;
    bus2.in_data = 8'hB4; bus2.in_last = 1'b0; bus2.in_valid = 1'b1;
    step();
    bus2.in_valid = 1'b0;
    checks++;
    if (bus2.sym_valid !== 1'b0) $display("FAIL slow_pre: got valid=%b want 0", bus2.sym_valid);
    else passed++;
    for (int c = 1; c <= 17; c++) begin
      en = ((c - 1) % 4 == 0);
      step();
      got = {bus2.sym_valid, bus2.sym_last, bus2.sym_data};
      if (c <= 16) want = {1'b1, 1'b0, exp[(c - 1) / 4]};
      else         want = 4'b0000;
      checks++;
      if (got !== want) $display("FAIL slow_cycle%0d: got v/l/d=%b want %b", c, got, want);
      else passed++;
    end
    en = 1'b1;
  endtask

  task automatic test_underrun;
    logic [3:0] got, want;
    step();
    bus2.in_data = 8'hFF; bus2.in_last = 1'b0; bus2.in_valid = 1'b1;
    step();
    bus2.in_valid = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      step();
      got = {bus2.sym_valid, bus2.sym_last, bus2.sym_data};
      if (c <= 5)       want = 4'b1011;
      else if (c <= 11) want = 4'b0000;
      else if (c <= 15) want = 4'b1000;
      else              want = 4'b0000;
      checks++;
      if (got !== want) $display("FAIL underrun_cycle%0d: got v/l/d=%b want %b", c, got, want);
      else passed++;
      if (c == 10) begin
        bus2.in_data = 8'h00; bus2.in_last = 1'b0; bus2.in_valid = 1'b1;
      end
      if (c == 11) bus2.in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_word;
    logic [1:0] exp [4];
    logic [3:0] got, want;
    exp[0] = 2'd2; exp[1] = 2'd2; exp[2] = 2'd1; exp[3] = 2'd1;
    step();
    bus2.in_data = 8'hB4; bus2.in_last = 1'b1; bus2.in_valid = 1'b1;
    step();
    bus2.in_valid = 1'b0;
    step();
    step();
    checks++;
    if ({bus2.sym_valid, bus2.sym_data} !== 3'b101) $display("FAIL rst_mid_sym1: got v/d=%b want 101", {bus2.sym_valid, bus2.sym_data});
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (bus2.in_ready !== 1'b0) $display("FAIL rst_mid_ready_comb: got %b want 0", bus2.in_ready);
    else passed++;
    step();
    checks++;
    if ({bus2.sym_valid, bus2.busy, bus2.in_ready} !== 3'b000) $display("FAIL rst_mid_cleared: got v/busy/rdy=%b want 000", {bus2.sym_valid, bus2.busy, bus2.in_ready});
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (bus2.in_ready !== 1'b1) $display("FAIL rst_mid_release_ready: got %b want 1", bus2.in_ready);
    else passed++;
    bus2.in_data = 8'h5A; bus2.in_last = 1'b0; bus2.in_valid = 1'b1;
    step();
    bus2.in_valid = 1'b0;
    checks++;
    if (bus2.sym_valid !== 1'b0) $display("FAIL rst_mid_no_stale: got valid=%b want 0", bus2.sym_valid);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      step();
      got  = {bus2.sym_valid, bus2.sym_last, bus2.sym_data};
      want = {1'b1, 1'b0, exp[k]};
      checks++;
      if (got !== want) $display("FAIL rst_mid_sym%0d: got v/l/d=%b want %b", k, got, want);
      else passed++;
    end
    step();
    checks++;
    if (bus2.sym_valid !== 1'b0) $display("FAIL rst_mid_end: got valid=%b want 0", bus2.sym_valid);
    else passed++;
  endtask

  task automatic test_ratio_one;
    logic [7:0] words [3];
    logic [9:0] got, want;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    step();
    for (int k = 0; k < 3; k++) begin
      bus8.in_data = words[k]; bus8.in_last = (k == 2); bus8.in_valid = 1'b1;
      #1;
      checks++;
      if (bus8.in_ready !== 1'b1) $display("FAIL r1_ready%0d: got %b want 1", k, bus8.in_ready);
      else passed++;
      step();
      if (k > 0) begin
        got  = {bus8.sym_valid, bus8.sym_last, bus8.sym_data};
        want = {1'b1, 1'b0, words[k - 1]};
        checks++;
        if (got !== want) $display("FAIL r1_sym%0d: got v/l/d=%h want %h", k - 1, got, want);
        else passed++;
      end
    end
    bus8.in_valid = 1'b0;
    step();
    got  = {bus8.sym_valid, bus8.sym_last, bus8.sym_data};
    want = {1'b1, 1'b1, 8'h33};
    checks++;
    if (got !== want) $display("FAIL r1_sym2: got v/l/d=%h want %h", got, want);
    else passed++;
    step();
    checks++;
    if ({bus8.sym_valid, bus8.busy} !== 2'b00) $display("FAIL r1_end: got valid/busy=%b want 00", {bus8.sym_valid, bus8.busy});
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    en  = 1'b1;
    bus2.in_data = 8'h00; bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
    bus8.in_data = 8'h00; bus8.in_valid = 1'b0; bus8.in_last = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_slow_strobe();
    test_underrun();
    test_reset_mid_word();
    test_ratio_one();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tx_symbol_serializer.md
# tx_symbol_serializer

Parallel-in, serial-out symbol serializer for the Ethernet transmit path. It accepts DATAW-bit words over a valid/ready handshake and emits them LSB-first as SYMW-bit symbols, one symbol per `enable` strobe. Typical configurations are a byte to MII nibbles (SYMW=4) or a byte to RMII dibits (SYMW=2). A one-word holding buffer lets consecutive words stream with no gap between them.

## Interface
Parameters:
- DATAW, 8, input word width.
- SYMW, 2, output symbol width. Must divide DATAW, and SYMW ≤ DATAW.
- RATIO, DATAW/SYMW, symbols per word (derived).
- CNTW, $clog2(RATIO+1), symbol-counter width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  symbol strobe: one symbol slot per high cycle. It is continuously 1 at 100M, and one cycle in N at 10M.
- in_data  in  DATAW  word to transmit.
- in_valid  in  1  in_data/in_last are valid.
- in_last  in  1  word is the last word of the frame.
- in_ready  out  1  the word is accepted on a clk edge where in_valid && in_ready.
- sym_data  out  SYMW  current output symbol.
- sym_valid  out  1  sym_data is a real symbol (TX_EN equivalent).
- sym_last  out  1  sym_data is the final symbol of a last-tagged word.
- busy  out  1  hold_valid || cnt != 0.

## Operation
State:
- Holding buffer: hold_data, hold_last, hold_valid.
- Shifter: sh_data (DATAW), sh_last, cnt (CNTW) = symbols remaining in the shifter.

Input handshake:
- in_ready = !reset && (!hold_valid || hold_drain), where hold_drain = enable && cnt ≤ 1 && hold_valid.
- in_ready is combinational from enable and registered state. There is no path from in_valid to in_ready.
- On acceptance: hold_data, hold_last and hold_valid are loaded and set to 1. If the buffer drains and a new word is accepted on the same edge, hold is reloaded and hold_valid stays 1.

On an enable cycle (all outputs are registered and updated only on enable edges):
- cnt ≥ 2:
  - emit sh_data[SYMW-1:0]; sym_valid=1; sym_last=0.
  - sh_data >>= SYMW; cnt -= 1.
- cnt == 1:
  - emit sh_data[SYMW-1:0]; sym_valid=1; sym_last=sh_last.
  - If hold_valid: sh_data=hold_data, sh_last=hold_last, cnt=RATIO, and hold is consumed. Otherwise cnt=0.
- cnt == 0 and hold_valid:
  - emit hold_data[SYMW-1:0]; sym_valid=1; sym_last=hold_last && RATIO==1.
  - sh_data=hold_data>>SYMW; sh_last=hold_last; cnt=RATIO-1; hold is consumed.
- cnt == 0 and no hold (underrun or idle): sym_valid=0, sym_data=0, sym_last=0.

On non-enable cycles, sym_data, sym_valid, sym_last, the shifter and cnt hold their values.

Symbol order: symbol k of a word is in_data[(k+1)*SYMW-1 : k*SYMW], for k=0..RATIO-1.

in_last affects only sym_last. Frame boundaries never insert gaps; the inter-frame gap is the upstream's responsibility.

## Timing
- Reset values: sym_data=0, sym_valid=0, sym_last=0, busy=0, in_ready=0 while reset is high.
- Reset internals: hold_valid=0, cnt=0, sh_data=0, sh_last=0.
- in_ready is 1 on the first cycle after reset deasserts.
- Reset mid-word: the hold and shifter contents are discarded. sym_valid=0 from the edge after reset is sampled. No partial symbol is emitted after reset.
- Latency: a word accepted at edge E0 with the block idle appears as symbol 0 on the first enable edge at or after E0+1. With enable=1 throughout, that is 1 cycle after the accept edge.
- Throughput: one word per RATIO enable cycles.
  - The output is gapless if the next word is accepted no later than the enable edge that emits the current word's last symbol.
  - RATIO==1 also sustains one word per enable, through hold_drain.
- sym_valid drops on the enable edge after the last symbol if no word is pending.

## Test plan
All scenarios use DATAW=8, SYMW=2 unless stated.
- Single word, enable=1: 0xB4 with last=1.
  - sym_data 0,1,3,2 on 4 consecutive cycles starting 1 cycle after accept.
  - sym_last=1 only on the symbol "2". sym_valid=0 on the next cycle. busy returns to 0.
- Back-to-back, enable=1: 0xB4 (last=0) then 0x5A (last=1), in_valid held high.
  - 8 contiguous symbols 0,1,3,2,2,2,1,1 with no sym_valid gap.
  - sym_last only on the 8th symbol.
  - in_ready low while hold is full and not draining.
- Slow strobe: enable high one cycle in 4, word 0xB4.
  - Each symbol is held stable for 4 cycles.
  - Outputs do not change on non-enable edges.
  - Total output duration is 16 cycles.
- Underrun: 0xFF, then a 6-enable gap, then 0x00.
  - Symbols 3,3,3,3, then sym_valid=0 with sym_data=0 for the remaining enables, then 0,0,0,0 with sym_valid=1.
- Reset mid-word: 0xB4 accepted, then reset pulsed after 2 symbols.
  - sym_valid=0, busy=0 and in_ready=0 from the edge after reset.
  - in_ready=1 after release.
  - The next word 0x5A produces 2,2,1,1 only.
- SYMW=8 (RATIO=1), enable=1: words 0x11, 0x22, 0x33 (last).
  - One word per cycle with in_ready held 1.
  - sym_data 0x11, 0x22, 0x33, with sym_last on 0x33.
